upc_sequencer: RTL

UPC_SEQUENCER -- requirements
Module: upc_sequencer

---
 rtl/upc_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/upc_sequencer.sv
// upc_sequencer: microprogram address sequencer with inc / load / call / ret.
// Optional return-address stack is compiled in with macro UPC_SEQ_STACK_EN;
// without it, call acts as load, ret acts as hold and the stack flags are constant.
module upc_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Enable,
  input  logic [2:0]        Op,
  input  logic [ADDR_W-1:0] D,
  output logic [ADDR_W-1:0] Q,
  output logic              StackFull,
  output logic              StackEmpty,
  output logic              StackErr
);

  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  // Reject stack depths outside the supported range at elaboration
  if (STACK_DEPTH < 1 || STACK_DEPTH > 16) begin : g_bad_depth
    $error("upc_sequencer: STACK_DEPTH must be in 1..16");
  end

  logic [ADDR_W-1:0] q_r;
  logic [ADDR_W-1:0] q_nxt;
  logic [ADDR_W-1:0] q_inc;

  assign q_inc = q_r + ADDR_W'(1);
  assign Q     = q_r;

`ifdef UPC_SEQ_STACK_EN

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [PTR_W-1:0]  sp_nxt;
  logic              err_r;
  logic              err_nxt;
  logic              push;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] top;

  assign full  = (sp_r == PTR_W'(STACK_DEPTH));
  assign empty = (sp_r == '0);
  assign top   = stack_mem[IDX_W'(sp_r - PTR_W'(1))];

  assign StackFull  = full;
  assign StackEmpty = empty;
  assign StackErr   = err_r;

  // Next-state decode of address, stack pointer and sticky error
  always_comb begin
    q_nxt   = q_r;
    sp_nxt  = sp_r;
    err_nxt = err_r;
    push    = 1'b0;
    if (Enable) begin
      case (Op)
        OP_INC:  q_nxt = q_inc;
        OP_LOAD: q_nxt = D;
        OP_CALL: begin
          if (!full) begin
            push   = 1'b1;
            sp_nxt = sp_r + PTR_W'(1);
            q_nxt  = D;
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            sp_nxt = sp_r - PTR_W'(1);
            q_nxt  = top;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers; reset wins over any operation
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_r   <= ADDR_W'(RESET_ADDR);
      sp_r  <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      sp_r  <= sp_nxt;
      err_r <= err_nxt;
    end
  end

  // Return-address storage; suppressed on reset so no partial push lands
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      stack_mem[IDX_W'(sp_r)] <= q_inc;
    end
  end

`else

  assign StackFull  = 1'b0;
  assign StackEmpty = 1'b1;
  assign StackErr   = 1'b0;

  // Next-address decode without a stack: call jumps, ret holds
  always_comb begin
    q_nxt = q_r;
    if (Enable) begin
      case (Op)
        OP_INC:  q_nxt = q_inc;
        OP_LOAD: q_nxt = D;
        OP_CALL: q_nxt = D;
        default: ;
      endcase
    end
  end

  // Address register; reset wins over any operation
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_r <= ADDR_W'(RESET_ADDR);
    end else begin
      q_r <= q_nxt;
    end
  end

`endif

endmodule
